// File: rtl/sequence_counter_pkg.sv
// Shared controller/datapath constants for the timing-state sequencer.
package sequence_counter_pkg;

  localparam int unsigned SC_CNT_WIDTH = 4;
  localparam int unsigned SC_T_WIDTH   = 2 ** SC_CNT_WIDTH;

  // Timing-state indices used by the controller's case decode.
  localparam int unsigned T0_IDX = 0;
  localparam int unsigned T1_IDX = 1;
  localparam int unsigned T2_IDX = 2;
  localparam int unsigned T3_IDX = 3;
  localparam int unsigned T4_IDX = 4;
  localparam int unsigned T5_IDX = 5;
  localparam int unsigned T6_IDX = 6;

  // Count-register update selected each cycle.
  typedef enum logic [1:0] {
    SC_HOLD  = 2'd0,
    SC_CLEAR = 2'd1,
    SC_INCR  = 2'd2
  } sc_action_e;

  // CLR beats INR; INR only advances while running.
  function automatic sc_action_e sc_select_action(input logic clr, input logic inr,
                                                  input logic run);
    if (clr)             return SC_CLEAR;
    else if (inr && run) return SC_INCR;
    else                 return SC_HOLD;
  endfunction

endpackage

// File: rtl/sequence_counter_decoder.sv
// One-hot decoder with active-high enable; all outputs low when disabled.
module sc_decoder #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 16
) (
  input  logic             en_i,
  input  logic [IN_W-1:0]  sel_i,
  output logic [OUT_W-1:0] onehot_o
);

  // Compare each output index against the select; keeps out-of-range indices safe.
  always_comb begin
    onehot_o = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      onehot_o[k] = en_i && (sel_i == IN_W'(k));
    end
  end

endmodule

// File: rtl/sequence_counter.sv
// Timing-state generator: count register plus next-state mux, decoded to T.
module sequence_counter
  import sequence_counter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = SC_CNT_WIDTH,
  parameter int unsigned T_WIDTH   = SC_T_WIDTH
) (
  input  logic               clk,
  input  logic               CLR,
  input  logic               INR,
  input  logic               S,
  output logic [T_WIDTH-1:0] T
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  sc_action_e           action;

  // Next-count selection: clear, increment (wraps naturally), or hold.
  always_comb begin
    count_d = count_q;
    action  = sc_select_action(CLR, INR, S);
    case (action)
      SC_CLEAR: count_d = '0;
      SC_INCR:  count_d = count_q + CNT_WIDTH'(1);
      default:  count_d = count_q;
    endcase
  end

  // Count register; CLR doubles as the synchronous reset.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  sc_decoder #(
    .IN_W  (CNT_WIDTH),
    .OUT_W (T_WIDTH)
  ) u_decoder (
    .en_i     (S),
    .sel_i    (count_q),
    .onehot_o (T)
  );

endmodule

// File: tb/tb_sequence_counter.sv
// Directed bench for sequence_counter with hand-computed T values.
module tb_sequence_counter;

  logic        clk;
  logic        CLR;
  logic        INR;
  logic        S;
  logic [15:0] T;

  int unsigned checks;
  int unsigned failures;

  sequence_counter #(
    .CNT_WIDTH (4),
    .T_WIDTH   (16)
  ) dut (
    .clk (clk),
    .CLR (CLR),
    .INR (INR),
    .S   (S),
    .T   (T)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle outputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] incr_exp [6];
    checks   = 0;
    failures = 0;
    incr_exp = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040};

    CLR = 1'b1; INR = 1'b0; S = 1'b1;
    #2;
    // Reset
    step();
    check("reset", T, 16'h0001);
    CLR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", T, 16'h0001);
    end

    // Increment
    INR = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("incr", T, incr_exp[i]);
    end

    // Wrap from T0
    INR = 1'b0; CLR = 1'b1;
    step();
    check("wrap_clear", T, 16'h0001);
    CLR = 1'b0; INR = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("wrap", T, (i == 16) ? 16'h0001 : (16'h0001 << i));
    end
    check("wrap_end", T, 16'h0001);

    // Priority: CLR and INR together at T3
    for (int i = 0; i < 3; i++) step();
    check("prio_at_t3", T, 16'h0008);
    CLR = 1'b1;
    step();
    check("prio_clear_wins", T, 16'h0001);

    // Halt at T3
    CLR = 1'b0; INR = 1'b1;
    for (int i = 0; i < 3; i++) step();
    INR = 1'b0;
    check("halt_pre", T, 16'h0008);
    S = 1'b0;
    #1;
    check("halt_comb", T, 16'h0000);
    INR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_hold", T, 16'h0000);
    end
    INR = 1'b0;
    S = 1'b1;
    #1;
    check("halt_resume", T, 16'h0008);

    // Clear while halted
    S = 1'b0; CLR = 1'b1;
    step();
    check("halt_clear_t", T, 16'h0000);
    CLR = 1'b0;
    step();
    check("halt_clear_idle", T, 16'h0000);
    S = 1'b1;
    #1;
    check("halt_clear_resume", T, 16'h0001);

    // Restart counting after resume
    INR = 1'b1;
    step();
    check("resume_incr", T, 16'h0002);
    INR = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
